// File: rtl/rob_param_if.sv
// rtl/rob_param_if.sv - allocate, completion, commit and redirect bundle for rob_param
interface rob_param_if #(
  parameter int DEPTH    = 16,
  parameter int IDX_W    = $clog2(DEPTH),
  parameter int ISSUE_W  = 4,
  parameter int CDB_W    = 4,
  parameter int COMMIT_W = 4,
  parameter int DATA_W   = 16,
  parameter int REG_W    = 4
);
  logic [ISSUE_W-1:0]          alloc_valid_flat;
  logic [ISSUE_W*REG_W-1:0]    alloc_target_flat;
  logic [ISSUE_W-1:0]          alloc_halt_flat;
  logic                        alloc_ready;
  logic [ISSUE_W*IDX_W-1:0]    alloc_index_flat;
  logic [CDB_W-1:0]            cdb_valid_flat;
  logic [CDB_W*IDX_W-1:0]      cdb_index_flat;
  logic [CDB_W*DATA_W-1:0]     cdb_value_flat;
  logic [CDB_W-1:0]            cdb_flush_flat;
  logic [DEPTH-1:0]            out_finished_flat;
  logic [DEPTH*DATA_W-1:0]     out_values_flat;
  logic [COMMIT_W-1:0]         reg_we_flat;
  logic [COMMIT_W*REG_W-1:0]   reg_target_flat;
  logic [COMMIT_W*DATA_W-1:0]  reg_data_flat;
  logic [COMMIT_W*IDX_W-1:0]   reg_writer_flat;
  logic                        flush_pipeline;
  logic [DATA_W-1:0]           pc_target;
  logic                        halted;
  logic [IDX_W:0]              count;
  logic [IDX_W-1:0]            head;

  modport master (
    output alloc_valid_flat, alloc_target_flat, alloc_halt_flat,
    output cdb_valid_flat, cdb_index_flat, cdb_value_flat, cdb_flush_flat,
    input  alloc_ready, alloc_index_flat, out_finished_flat, out_values_flat,
    input  reg_we_flat, reg_target_flat, reg_data_flat, reg_writer_flat,
    input  flush_pipeline, pc_target, halted, count, head
  );

  modport slave (
    input  alloc_valid_flat, alloc_target_flat, alloc_halt_flat,
    input  cdb_valid_flat, cdb_index_flat, cdb_value_flat, cdb_flush_flat,
    output alloc_ready, alloc_index_flat, out_finished_flat, out_values_flat,
    output reg_we_flat, reg_target_flat, reg_data_flat, reg_writer_flat,
    output flush_pipeline, pc_target, halted, count, head
  );
endinterface

// File: rtl/rob_param.sv
// rtl/rob_param.sv - parametrised reorder buffer; ROB_BYPASS_EN exposes per-entry finished/value
module rob_param #(
  parameter int DEPTH    = 16,
  parameter int IDX_W    = $clog2(DEPTH),
  parameter int ISSUE_W  = 4,
  parameter int CDB_W    = 4,
  parameter int COMMIT_W = 4,
  parameter int DATA_W   = 16,
  parameter int REG_W    = 4
) (
  input logic       clk,
  input logic       reset,
  rob_param_if.slave bus
);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0]  head_q, tail_q, count_w, n_alloc, n_commit;
  logic [DEPTH-1:0]  fin_q, flush_q, halt_q;
  logic [REG_W-1:0]  target_q [DEPTH];
  logic [DATA_W-1:0] value_q  [DEPTH];
  logic              halted_q, flush_out_q, alloc_ready_w, alloc_go;
  logic [DATA_W-1:0] pc_q, flush_val;
  logic              flush_commit, halt_commit;

  logic [IDX_W-1:0]  aidx [ISSUE_W];
  logic [ISSUE_W-1:0] a_valid, a_halt;
  logic [REG_W-1:0]  a_target [ISSUE_W];
  logic [IDX_W-1:0]  c_idx [CDB_W];
  logic [DATA_W-1:0] c_val [CDB_W];
  logic [CDB_W-1:0]  c_ok, c_flush;
  logic [IDX_W-1:0]  cidx [COMMIT_W];
  logic [COMMIT_W-1:0] commit_w, we_w, we_q;
  logic [REG_W-1:0]  rt_q [COMMIT_W];
  logic [DATA_W-1:0] rd_q [COMMIT_W];
  logic [IDX_W-1:0]  rw_q [COMMIT_W];

  assign count_w       = head_q - tail_q;
  assign alloc_ready_w = ((PTR_W'(DEPTH) - count_w) >= PTR_W'(ISSUE_W)) && !halted_q && !flush_out_q;
  // Allocations that land in a flush-commit cycle are wrong-path and are dropped.
  assign alloc_go      = alloc_ready_w && !flush_commit;

  for (genvar i = 0; i < ISSUE_W; i++) begin : g_alloc
    assign aidx[i]     = head_q[IDX_W-1:0] + IDX_W'(i);
    assign a_valid[i]  = bus.alloc_valid_flat[ISSUE_W-1-i];
    assign a_halt[i]   = bus.alloc_halt_flat[ISSUE_W-1-i];
    assign a_target[i] = bus.alloc_target_flat[(ISSUE_W-1-i)*REG_W +: REG_W];
    assign bus.alloc_index_flat[(ISSUE_W-1-i)*IDX_W +: IDX_W] = aidx[i];
  end

  for (genvar j = 0; j < CDB_W; j++) begin : g_cdb
    logic [IDX_W-1:0] rel;
    assign c_idx[j]   = bus.cdb_index_flat[(CDB_W-1-j)*IDX_W +: IDX_W];
    assign c_val[j]   = bus.cdb_value_flat[(CDB_W-1-j)*DATA_W +: DATA_W];
    assign c_flush[j] = bus.cdb_flush_flat[CDB_W-1-j];
    assign rel        = c_idx[j] - tail_q[IDX_W-1:0];
    // Only entries currently between tail and head may be completed.
    assign c_ok[j]    = bus.cdb_valid_flat[CDB_W-1-j] && ({1'b0, rel} < count_w);
  end

  for (genvar k = 0; k < COMMIT_W; k++) begin : g_cidx
    assign cidx[k] = tail_q[IDX_W-1:0] + IDX_W'(k);
    assign bus.reg_we_flat[COMMIT_W-1-k]                         = we_q[k];
    assign bus.reg_target_flat[(COMMIT_W-1-k)*REG_W +: REG_W]    = rt_q[k];
    assign bus.reg_data_flat[(COMMIT_W-1-k)*DATA_W +: DATA_W]    = rd_q[k];
    assign bus.reg_writer_flat[(COMMIT_W-1-k)*IDX_W +: IDX_W]    = rw_q[k];
  end

  // Count valid allocate lanes (lanes are contiguous from lane 0).
  always_comb begin
    n_alloc = '0;
    for (int i = 0; i < ISSUE_W; i++)
      if (a_valid[i]) n_alloc = n_alloc + PTR_W'(1);
  end

  // In-order commit chain; a flush or halt entry commits but stops every later lane.
  always_comb begin
    logic go;
    go           = !halted_q;
    commit_w     = '0;
    we_w         = '0;
    n_commit     = '0;
    flush_commit = 1'b0;
    halt_commit  = 1'b0;
    flush_val    = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      if (go && (PTR_W'(k) < count_w) && fin_q[cidx[k]]) begin
        commit_w[k] = 1'b1;
        n_commit    = n_commit + PTR_W'(1);
        if (flush_q[cidx[k]]) begin
          flush_commit = 1'b1;
          flush_val    = value_q[cidx[k]];
          go           = 1'b0;
        end else if (halt_q[cidx[k]]) begin
          halt_commit = 1'b1;
          go          = 1'b0;
        end else begin
          we_w[k] = 1'b1;
        end
      end else begin
        go = 1'b0;
      end
    end
  end

  // Pointers, per-entry status bits and registered control outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      fin_q       <= '0;
      flush_q     <= '0;
      we_q        <= '0;
      flush_out_q <= 1'b0;
      pc_q        <= '0;
      halted_q    <= 1'b0;
    end else begin
      for (int k = 0; k < COMMIT_W; k++)
        if (commit_w[k]) fin_q[cidx[k]] <= 1'b0;
      for (int j = 0; j < CDB_W; j++)
        if (c_ok[j]) begin
          fin_q[c_idx[j]]   <= 1'b1;
          flush_q[c_idx[j]] <= c_flush[j];
        end
      if (alloc_go)
        for (int i = 0; i < ISSUE_W; i++)
          if (a_valid[i]) begin
            fin_q[aidx[i]]   <= a_halt[i];
            flush_q[aidx[i]] <= 1'b0;
          end
      if (flush_commit) begin
        tail_q <= head_q;
        pc_q   <= flush_val;
      end else begin
        tail_q <= tail_q + n_commit;
        if (alloc_go) head_q <= head_q + n_alloc;
      end
      we_q        <= we_w;
      flush_out_q <= flush_commit;
      halted_q    <= halted_q | halt_commit;
    end
  end

  // Entry payloads are never cleared; they are rewritten on allocate/completion.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int j = 0; j < CDB_W; j++)
        if (c_ok[j]) value_q[c_idx[j]] <= c_val[j];
      if (alloc_go)
        for (int i = 0; i < ISSUE_W; i++)
          if (a_valid[i]) begin
            target_q[aidx[i]] <= a_target[i];
            halt_q[aidx[i]]   <= a_halt[i];
          end
    end
  end

  // Commit payload is captured every cycle; only lanes with reg_we set are meaningful.
  always_ff @(posedge clk) begin
    for (int k = 0; k < COMMIT_W; k++) begin
      rt_q[k] <= target_q[cidx[k]];
      rd_q[k] <= value_q[cidx[k]];
      rw_q[k] <= cidx[k];
    end
  end

  assign bus.alloc_ready    = alloc_ready_w;
  assign bus.flush_pipeline = flush_out_q;
  assign bus.pc_target      = pc_q;
  assign bus.halted         = halted_q;
  assign bus.count          = count_w;
  assign bus.head           = head_q[IDX_W-1:0];

`ifdef ROB_BYPASS_EN
  for (genvar e = 0; e < DEPTH; e++) begin : g_byp
    assign bus.out_finished_flat[DEPTH-1-e]                  = fin_q[e];
    assign bus.out_values_flat[(DEPTH-1-e)*DATA_W +: DATA_W] = value_q[e];
  end
`else
  assign bus.out_finished_flat = '0;
  assign bus.out_values_flat   = '0;
`endif
endmodule

// File: tb/tb_rob_param.sv
// tb/tb_rob_param.sv - directed self-checking bench for rob_param
module tb_rob_param;
  localparam int DEPTH = 16, IDX_W = 4, ISSUE_W = 4, CDB_W = 4, COMMIT_W = 4, DATA_W = 16, REG_W = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rob_param_if #(.DEPTH(DEPTH), .IDX_W(IDX_W), .ISSUE_W(ISSUE_W), .CDB_W(CDB_W),
                 .COMMIT_W(COMMIT_W), .DATA_W(DATA_W), .REG_W(REG_W)) bus ();

  rob_param #(.DEPTH(DEPTH), .IDX_W(IDX_W), .ISSUE_W(ISSUE_W), .CDB_W(CDB_W),
              .COMMIT_W(COMMIT_W), .DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alloc_valid_flat  = '0;
    bus.alloc_target_flat = '0;
    bus.alloc_halt_flat   = '0;
    bus.cdb_valid_flat    = '0;
    bus.cdb_index_flat    = '0;
    bus.cdb_value_flat    = '0;
    bus.cdb_flush_flat    = '0;
  endtask

  task automatic alloc4(input logic [15:0] tgts);
    bus.alloc_valid_flat  = 4'b1111;
    bus.alloc_target_flat = tgts;
    bus.alloc_halt_flat   = 4'b0000;
  endtask

  task automatic cdb(input int lane, input logic [3:0] idx, input logic [15:0] val, input logic fl);
    bus.cdb_valid_flat[CDB_W-1-lane]                     = 1'b1;
    bus.cdb_index_flat[(CDB_W-1-lane)*IDX_W +: IDX_W]    = idx;
    bus.cdb_value_flat[(CDB_W-1-lane)*DATA_W +: DATA_W]  = val;
    bus.cdb_flush_flat[CDB_W-1-lane]                     = fl;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_count", bus.count, 0);
    check("rst_head", bus.head, 0);
    check("rst_we", bus.reg_we_flat, 0);
    check("rst_flush", bus.flush_pipeline, 0);
    check("rst_pc", bus.pc_target, 0);
    check("rst_halted", bus.halted, 0);
    check("rst_ready", bus.alloc_ready, 1);
    check("rst_aidx", bus.alloc_index_flat, 16'h0123);

    // in-order group: allocate, complete all, retire together
    alloc4(16'h1234); step(); idle();
    check("p1_count", bus.count, 4);
    check("p1_head", bus.head, 4);
    check("p1_aidx", bus.alloc_index_flat, 16'h4567);
    cdb(0, 4'd0, 16'h0011, 1'b0); cdb(1, 4'd1, 16'h0022, 1'b0);
    cdb(2, 4'd2, 16'h0033, 1'b0); cdb(3, 4'd3, 16'h0044, 1'b0);
    step(); idle();
    check("p1_we_early", bus.reg_we_flat, 0);
    check("p1_count_mid", bus.count, 4);
    step();
    check("p1_we", bus.reg_we_flat, 4'b1111);
    check("p1_data", bus.reg_data_flat, 64'h0011_0022_0033_0044);
    check("p1_target", bus.reg_target_flat, 16'h1234);
    check("p1_writer", bus.reg_writer_flat, 16'h0123);
    check("p1_count_end", bus.count, 0);
    step();
    check("p1_we_pulse", bus.reg_we_flat, 0);

    // out-of-order completion: 6,7 first, then 4,5
    alloc4(16'h5678); step(); idle();
    cdb(0, 4'd6, 16'h0106, 1'b0); cdb(1, 4'd7, 16'h0107, 1'b0);
    step(); idle();
    check("p2_we_a", bus.reg_we_flat, 0);
    step();
    check("p2_we_b", bus.reg_we_flat, 0);
    check("p2_count_b", bus.count, 4);
    cdb(0, 4'd4, 16'h0104, 1'b0); cdb(1, 4'd5, 16'h0105, 1'b0);
    step(); idle();
    check("p2_we_c", bus.reg_we_flat, 0);
    step();
    check("p2_we", bus.reg_we_flat, 4'b1111);
    check("p2_data", bus.reg_data_flat, 64'h0104_0105_0106_0107);
    check("p2_writer", bus.reg_writer_flat, 16'h4567);
    check("p2_target", bus.reg_target_flat, 16'h5678);
    check("p2_count", bus.count, 0);
    check("p2_head", bus.head, 8);

    // fill to DEPTH, fifth group dropped
    do_reset();
    alloc4(16'h1111);
    step(); check("p3_count4", bus.count, 4);
    step(); check("p3_count8", bus.count, 8);
    step(); check("p3_count12", bus.count, 12);
    check("p3_ready12", bus.alloc_ready, 1);
    step(); check("p3_count16", bus.count, 16);
    check("p3_ready16", bus.alloc_ready, 0);
    check("p3_head16", bus.head, 0);
    step(); idle();
    check("p3_count_drop", bus.count, 16);
    check("p3_head_drop", bus.head, 0);

    // mispredicted branch at idx 1; allocation in the flush-commit cycle is discarded
    do_reset();
    alloc4(16'h9abc); step(); idle();
    cdb(0, 4'd0, 16'h00a0, 1'b0); cdb(1, 4'd1, 16'h0200, 1'b1);
    cdb(2, 4'd2, 16'h00a2, 1'b0); cdb(3, 4'd3, 16'h00a3, 1'b0);
    step(); idle();
    check("p4_we_early", bus.reg_we_flat, 0);
    check("p4_flush_early", bus.flush_pipeline, 0);
    alloc4(16'hdddd);
    check("p4_ready_pre", bus.alloc_ready, 1);
    step(); idle();
    check("p4_we", bus.reg_we_flat, 4'b1000);
    check("p4_data0", bus.reg_data_flat[63:48], 16'h00a0);
    check("p4_target0", bus.reg_target_flat[15:12], 4'h9);
    check("p4_writer0", bus.reg_writer_flat[15:12], 4'h0);
    check("p4_flush", bus.flush_pipeline, 1);
    check("p4_pc", bus.pc_target, 16'h0200);
    check("p4_count", bus.count, 0);
    check("p4_head", bus.head, 4);
    check("p4_ready_flush", bus.alloc_ready, 0);
    step();
    check("p4_flush_drop", bus.flush_pipeline, 0);
    check("p4_we_after", bus.reg_we_flat, 0);
    check("p4_count_after", bus.count, 0);
    check("p4_ready_after", bus.alloc_ready, 1);

    // halt at idx 0
    do_reset();
    bus.alloc_valid_flat = 4'b1000;
    bus.alloc_halt_flat  = 4'b1000;
    step(); idle();
    check("p5_halted_a", bus.halted, 0);
    check("p5_count_a", bus.count, 1);
    step();
    check("p5_halted", bus.halted, 1);
    check("p5_we", bus.reg_we_flat, 0);
    check("p5_ready", bus.alloc_ready, 0);
    check("p5_count", bus.count, 0);
    alloc4(16'h2222); step(); idle();
    check("p5_count_drop", bus.count, 0);
    check("p5_head", bus.head, 1);
    check("p5_sticky", bus.halted, 1);

    // reset with 8 entries in flight and 4 ready to retire
    do_reset();
    check("p6_halt_clr", bus.halted, 0);
    alloc4(16'h1234); step();
    alloc4(16'h5678);
    cdb(0, 4'd0, 16'h0aa0, 1'b0); cdb(1, 4'd1, 16'h0aa1, 1'b0);
    cdb(2, 4'd2, 16'h0aa2, 1'b0); cdb(3, 4'd3, 16'h0aa3, 1'b0);
    step(); idle();
    check("p6_count8", bus.count, 8);
    reset = 1'b1;
    step();
    check("p6_count", bus.count, 0);
    check("p6_we", bus.reg_we_flat, 0);
    check("p6_flush", bus.flush_pipeline, 0);
    check("p6_head", bus.head, 0);
    reset = 1'b0;
    step();
    check("p6_we_after", bus.reg_we_flat, 0);
    check("p6_count_after", bus.count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
